incline_cond: RTL and testbench
===============================

Name: incline_cond

Overview:
- Downstream conditioner for the inertial interface's incline output.
- Consumes the 13-bit signed incline and its one-cycle vld strobe.
- Saturates each sample to 10-bit signed, keeps a boxcar average over the last 2^AVG_LOG2 samples, and watches for sensor dropout.
- Feeds the averaged incline to the assist/torque-target logic.

Parameters:
- AVG_LOG2, 3, log2 of the averaging window; window = 8 samples.
- TIMEOUT_W, 20, width of the dropout counter; timeout fires at 2^TIMEOUT_W-1 cycles without vld.
- DEADBAND, 8, deadband magnitude; used only when INCLINE_DEADBAND_EN is defined.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- vld  in  1  one-cycle strobe, new incline sample
- incline  in  13  signed incline sample
- incline_avg  out  10  signed averaged incline
- avg_vld  out  1  one-cycle strobe, incline_avg updated
- sat  out  1  current sample was clipped; valid with avg_vld
- primed  out  1  window fully filled since the last reset or flush
- stale  out  1  dropout occurred; no accepted sample since

Behaviour:
- Reset: all outputs 0, buffer entries 0, sum 0, write pointer 0, fill count 0, timeout counter 0, state FILL.
- Saturation: incline > 511 → 511; incline < -512 → -512; otherwise incline[9:0]. sat = 1 when clipped.
- Storage: circular buffer of 2^AVG_LOG2 entries × 10 bits, held in flops with async reset.
- Running sum: signed, width 10+AVG_LOG2.
- Accepted vld (state FILL or RUN):
  - sum <= sum + s − buf[wptr], where s is the saturated sample.
  - buf[wptr] <= s; wptr increments and wraps to 0 after 2^AVG_LOG2−1.
  - Timeout counter cleared; stale cleared.
- Output timing: avg_vld pulses exactly one cycle after the accepted vld.
  - incline_avg = updated sum >>> AVG_LOG2 (arithmetic, floor); holds between updates.
  - sat is registered alongside avg_vld.
- Latency: 1 cycle from vld to avg_vld.
- States (enum in package):
  - FILL: counts accepted samples. On the 2^AVG_LOG2-th sample → RUN, primed = 1, asserted in the same cycle as that avg_vld.
  - RUN: steady state.
  - FLUSH: writes 0 to one buffer entry per cycle, 2^AVG_LOG2 cycles total. Sum, wptr, fill count are zeroed on entry. Then → FILL with stale = 1 and primed = 0. vld during FLUSH is dropped: no avg_vld, no buffer update.
- Timeout:
  - In FILL/RUN with stale = 0, the counter increments each cycle without vld.
  - Counter reaching 2^TIMEOUT_W−1 with no vld that cycle → FLUSH.
  - While stale = 1 the counter is held at 0, so there is no repeated flushing.
  - vld in the same cycle as terminal count: vld wins, the sample is accepted, the counter clears, no flush.
  - The counter is held at 0 in FLUSH.
- Reset mid-FLUSH or mid-FILL: returns immediately to the reset state.
- Reset never sets stale.
- During FILL the average ramps, because empty entries count as 0.

Optional Feature:
- Macro INCLINE_DEADBAND_EN.
- Defined: if |computed average| < DEADBAND, incline_avg = 0. sum and buffer are unaffected.
- Undefined: no deadband logic; the DEADBAND parameter is unused.

Decomposition:
- Package incline_pkg holds:
  - state_t enum {FILL, RUN, FLUSH}
  - INC_SAT_MAX = 511
  - INC_SAT_MIN = -512
  - INC_OUT_W = 10
- One sub-module, incline_sat: combinational 13→10 saturator producing the sample and the sat flag.
- Buffer, sum, FSM and timeout all live in incline_cond.

Test Plan:
1. Assert then release rst_n → all outputs 0, primed = 0, stale = 0, no avg_vld.
2. 8 vld pulses with incline = 80, spaced 50 cycles → avg_vld 1 cycle after each; incline_avg = 10, 20, …, 80; primed rises with the 8th avg_vld; sat = 0.
3. Primed at 80, then incline = 4095 ×8 → sat = 1 each time, final avg 511. Then incline = -4096 ×8 → final avg -512.
4. Primed at 80, then incline = -80 ×4 → final incline_avg = 0.
5. TIMEOUT_W = 8, no vld for 255 cycles → FLUSH for 8 cycles; a vld injected mid-flush produces no avg_vld. Afterwards stale = 1, primed = 0. Next vld incline = 40 → avg 5, stale = 0.
6. TIMEOUT_W = 8, vld coincident with terminal count → sample accepted, no FLUSH, stale stays 0. With INCLINE_DEADBAND_EN defined, an average of 5 outputs 0.

Source files
------------

// File: rtl/incline_pkg.sv
// incline_pkg: shared types and constants for the incline conditioner.
//   state_t     - conditioner state (FILL, RUN, FLUSH)
//   INC_SAT_MAX - upper saturation bound for a conditioned sample
//   INC_SAT_MIN - lower saturation bound for a conditioned sample
//   INC_OUT_W   - width of a conditioned (saturated / averaged) sample
package incline_pkg;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam int INC_SAT_MAX = 511;
  localparam int INC_SAT_MIN = -512;
  localparam int INC_OUT_W   = 10;

endpackage

// File: rtl/incline_sat.sv
// incline_sat: combinational 13-bit to 10-bit signed saturator.
// Ports:
//   incline (in, 13, signed)  raw incline sample
//   sample  (out, 10, signed) sample clipped to [INC_SAT_MIN, INC_SAT_MAX]
//   sat     (out, 1)          high when the sample had to be clipped
module incline_sat
  import incline_pkg::*;
(
  input  logic signed [12:0]          incline,
  output logic signed [INC_OUT_W-1:0] sample,
  output logic                        sat
);

  // In-range values fit in 10 bits unchanged, so the low bits are the sample.
  always_comb begin
    sample = incline[INC_OUT_W-1:0];
    sat    = 1'b0;
    if (int'(incline) > INC_SAT_MAX) begin
      sample = INC_OUT_W'(INC_SAT_MAX);
      sat    = 1'b1;
    end else if (int'(incline) < INC_SAT_MIN) begin
      sample = INC_OUT_W'(INC_SAT_MIN);
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/incline_cond.sv
// incline_cond: conditions the inertial interface's incline output for the
// assist/torque-target logic. Each accepted sample is saturated to 10 bits,
// pushed into a 2^AVG_LOG2-deep circular buffer, and the boxcar average of
// the buffer is published one cycle later. A dropout timer flushes the
// window when no sample arrives for 2^TIMEOUT_W-1 cycles.
// Optional feature: define INCLINE_DEADBAND_EN to force averages whose
// magnitude is below DEADBAND to zero (sum and buffer are unaffected).
// Ports:
//   clk         (in, 1)            clock
//   rst_n       (in, 1)            asynchronous active-low reset
//   vld         (in, 1)            one-cycle strobe, new incline sample
//   incline     (in, 13, signed)   raw incline sample
//   incline_avg (out, 10, signed)  averaged incline, held between updates
//   avg_vld     (out, 1)           one-cycle strobe, incline_avg updated
//   sat         (out, 1)           sample behind this avg_vld was clipped
//   primed      (out, 1)           window fully filled since reset/flush
//   stale       (out, 1)           dropout occurred, no sample since
module incline_cond
  import incline_pkg::*;
#(
  parameter int AVG_LOG2  = 3,
  parameter int TIMEOUT_W = 20,
  parameter int DEADBAND  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vld,
  input  logic signed [12:0]          incline,
  output logic signed [INC_OUT_W-1:0] incline_avg,
  output logic                        avg_vld,
  output logic                        sat,
  output logic                        primed,
  output logic                        stale
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W = INC_OUT_W + AVG_LOG2;

  state_t                      state_q, state_d;
  logic signed [INC_OUT_W-1:0] ring_q [DEPTH];
  logic signed [INC_OUT_W-1:0] ring_d [DEPTH];
  logic signed [SUM_W-1:0]     sum_q, sum_d;
  logic [AVG_LOG2-1:0]         wptr_q, wptr_d;
  logic [AVG_LOG2-1:0]         fill_q, fill_d;
  logic [TIMEOUT_W-1:0]        tmo_q, tmo_d;
  logic                        stale_q, stale_d;
  logic                        primed_q, primed_d;
  logic                        avg_vld_q, avg_vld_d;
  logic                        sat_q, sat_d;
  logic signed [INC_OUT_W-1:0] avg_q, avg_d;

  logic signed [INC_OUT_W-1:0] s_sample;
  logic                        s_sat;

  incline_sat u_sat (
    .incline (incline),
    .sample  (s_sample),
    .sat     (s_sat)
  );

  // Next-state logic. In FLUSH the write pointer doubles as the clear index:
  // it starts at 0 on entry and wraps back to 0 after the last entry, so the
  // window restarts cleanly at slot 0.
  always_comb begin
    state_d   = state_q;
    ring_d    = ring_q;
    sum_d     = sum_q;
    wptr_d    = wptr_q;
    fill_d    = fill_q;
    tmo_d     = tmo_q;
    stale_d   = stale_q;
    primed_d  = primed_q;
    avg_vld_d = 1'b0;
    sat_d     = sat_q;
    avg_d     = avg_q;

    case (state_q)
      FILL, RUN: begin
        if (vld) begin
          // Replace the oldest entry; the sum tracks the window incrementally.
          sum_d          = sum_q + SUM_W'(s_sample) - SUM_W'(ring_q[wptr_q]);
          ring_d[wptr_q] = s_sample;
          wptr_d         = wptr_q + 1'b1;
          tmo_d          = '0;
          stale_d        = 1'b0;
          avg_vld_d      = 1'b1;
          sat_d          = s_sat;
          avg_d          = INC_OUT_W'(sum_d >>> AVG_LOG2);
`ifdef INCLINE_DEADBAND_EN
          if ((int'(avg_d) < DEADBAND) && (int'(avg_d) > -DEADBAND)) begin
            avg_d = '0;
          end
`endif
          if (state_q == FILL) begin
            fill_d = fill_q + 1'b1;
            if (fill_q == '1) begin
              state_d  = RUN;
              primed_d = 1'b1;
            end
          end
        end else if (stale_q) begin
          // Already reported a dropout; hold the timer so we flush only once.
          tmo_d = '0;
        end else if (tmo_q == '1) begin
          state_d = FLUSH;
          sum_d   = '0;
          wptr_d  = '0;
          fill_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      FLUSH: begin
        ring_d[wptr_q] = '0;
        wptr_d         = wptr_q + 1'b1;
        tmo_d          = '0;
        if (wptr_q == '1) begin
          state_d  = FILL;
          stale_d  = 1'b1;
          primed_d = 1'b0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= '0;
      end
      sum_q     <= '0;
      wptr_q    <= '0;
      fill_q    <= '0;
      tmo_q     <= '0;
      stale_q   <= 1'b0;
      primed_q  <= 1'b0;
      avg_vld_q <= 1'b0;
      sat_q     <= 1'b0;
      avg_q     <= '0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < DEPTH; i++) begin
        ring_q[i] <= ring_d[i];
      end
      sum_q     <= sum_d;
      wptr_q    <= wptr_d;
      fill_q    <= fill_d;
      tmo_q     <= tmo_d;
      stale_q   <= stale_d;
      primed_q  <= primed_d;
      avg_vld_q <= avg_vld_d;
      sat_q     <= sat_d;
      avg_q     <= avg_d;
    end
  end

  assign incline_avg = avg_q;
  assign avg_vld     = avg_vld_q;
  assign sat         = sat_q;
  assign primed      = primed_q;
  assign stale       = stale_q;

endmodule

// File: tb/tb_incline_cond.sv
// tb_incline_cond: self-checking bench for incline_cond (TIMEOUT_W = 8).
// A reference model keeps the last 8 saturated samples in a queue and
// derives the average, sat, primed and stale flags from plain arithmetic.
module tb_incline_cond;

  localparam int AVG_LOG2  = 3;
  localparam int TIMEOUT_W = 8;
  localparam int DEADBAND  = 8;
  localparam int N         = 1 << AVG_LOG2;
  localparam int TERM      = (1 << TIMEOUT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               vld;
  logic signed [12:0] incline;
  logic signed [9:0]  incline_avg;
  logic               avg_vld;
  logic               sat;
  logic               primed;
  logic               stale;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int win[$];
  int filled;
  bit m_primed;
  bit m_stale;
  int idle;
  int flush_left;
  int exp_avg;
  bit exp_sat;
  bit exp_vld;

  incline_cond #(
    .AVG_LOG2  (AVG_LOG2),
    .TIMEOUT_W (TIMEOUT_W),
    .DEADBAND  (DEADBAND)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vld         (vld),
    .incline     (incline),
    .incline_avg (incline_avg),
    .avg_vld     (avg_vld),
    .sat         (sat),
    .primed      (primed),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  function automatic int sat_model(int x);
    if (x > 511) return 511;
    if (x < -512) return -512;
    return x;
  endfunction

  // Floor of the window mean, with the optional deadband applied.
  function automatic int window_avg();
    int sum = 0;
    int q;
    foreach (win[i]) sum += win[i];
    q = sum / N;
    if ((sum < 0) && ((sum % N) != 0)) q--;
`ifdef INCLINE_DEADBAND_EN
    if ((q < DEADBAND) && (q > -DEADBAND)) q = 0;
`endif
    return q;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    win = {};
    for (int i = 0; i < N; i++) win.push_back(0);
    filled     = 0;
    m_primed   = 1'b0;
    m_stale    = 1'b0;
    idle       = 0;
    flush_left = 0;
    exp_avg    = 0;
    exp_sat    = 1'b0;
    exp_vld    = 1'b0;
  endtask

  task automatic check_output();
    check("avg_vld", avg_vld, int'(exp_vld));
    check("incline_avg", incline_avg, exp_avg);
    check("sat", sat, int'(exp_sat));
    if (flush_left == 0) begin
      check("primed", primed, int'(m_primed));
      check("stale", stale, int'(m_stale));
    end
  endtask

  // One clock: drive at the falling edge, update the model at the rising
  // edge, compare at the next falling edge.
  task automatic cycle(input bit v, input int x);
    int s;
    vld     = v;
    incline = 13'(x);
    @(posedge clk);
    exp_vld = 1'b0;
    if (flush_left > 0) begin
      flush_left--;
      if (flush_left == 0) begin
        m_stale  = 1'b1;
        m_primed = 1'b0;
      end
    end else if (v) begin
      s       = sat_model(x);
      exp_sat = (s != x);
      void'(win.pop_front());
      win.push_back(s);
      filled++;
      if (filled >= N) m_primed = 1'b1;
      idle    = 0;
      m_stale = 1'b0;
      exp_vld = 1'b1;
      exp_avg = window_avg();
    end else if (m_stale) begin
      idle = 0;
    end else if (idle == TERM) begin
      flush_left = N;
      foreach (win[i]) win[i] = 0;
      filled = 0;
      idle   = 0;
    end else begin
      idle++;
    end
    @(negedge clk);
    vld     = 1'b0;
    incline = '0;
    check_output();
  endtask

  task automatic apply_stimulus(input int x, input int gap);
    cycle(1'b1, x);
    repeat (gap) cycle(1'b0, 0);
  endtask

  initial begin
    int x;
    rst_n   = 1'b0;
    vld     = 1'b0;
    incline = '0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state.
    check("reset_avg", incline_avg, 0);
    check("reset_avg_vld", avg_vld, 0);
    check("reset_sat", sat, 0);
    check("reset_primed", primed, 0);
    check("reset_stale", stale, 0);
    rst_n = 1'b1;
    cycle(1'b0, 0);

    // Ramp while filling: 8 samples of 80 spaced 50 cycles.
    $display("[TB] fill ramp");
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, 80);
      check("ramp_avg", incline_avg, 10 * (i + 1));
      check("ramp_primed", primed, (i == N - 1) ? 1 : 0);
      repeat (49) cycle(1'b0, 0);
    end

    // Saturation at both ends.
    $display("[TB] saturation");
    for (int i = 0; i < N; i++) apply_stimulus(4095, 3);
    check("sat_hi_avg", incline_avg, 511);
    for (int i = 0; i < N; i++) apply_stimulus(-4096, 3);
    check("sat_lo_avg", incline_avg, -512);

    // Re-prime at 80, then four samples of -80 cancel half the window.
    $display("[TB] cancel");
    for (int i = 0; i < N; i++) apply_stimulus(80, 2);
    check("reprime_avg", incline_avg, 80);
    for (int i = 0; i < 4; i++) apply_stimulus(-80, 2);
    check("cancel_avg", incline_avg, 0);

    // Dropout: idle until the flush, inject a sample mid-flush.
    $display("[TB] dropout flush");
    repeat (TERM + 1 - 2) cycle(1'b0, 0);
    repeat (3) cycle(1'b0, 0);
    cycle(1'b1, 100);
    check("flush_drop", avg_vld, 0);
    repeat (4) cycle(1'b0, 0);
    check("flush_stale", stale, 1);
    check("flush_primed", primed, 0);
    repeat (300) cycle(1'b0, 0);
    check("stale_held", stale, 1);
    cycle(1'b1, 40);
`ifdef INCLINE_DEADBAND_EN
    check("post_flush_avg", incline_avg, 0);
`else
    check("post_flush_avg", incline_avg, 5);
`endif
    check("post_flush_stale", stale, 0);
    repeat (3) cycle(1'b0, 0);

    // Sample coincident with terminal count wins over the flush.
    $display("[TB] terminal count race");
    repeat (TERM - 3) cycle(1'b0, 0);
    cycle(1'b1, -24);
    check("race_accept", avg_vld, 1);
    check("race_stale", stale, 0);
    repeat (20) cycle(1'b0, 0);

    // Randomized samples and gaps.
    $display("[TB] random");
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 8191)) - 4096;
      else x = int'($urandom_range(0, 1199)) - 600;
      apply_stimulus(x, int'($urandom_range(0, 6)));
    end

    // Asynchronous reset in the middle of a fill.
    $display("[TB] reset mid-fill");
    repeat (N) apply_stimulus(-40, 1);
    for (int i = 0; i < 3; i++) apply_stimulus(300, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_avg", incline_avg, 0);
    check("async_primed", primed, 0);
    check("async_sat", sat, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_stimulus(160, 2);
    check("refill_avg", incline_avg, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
